// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the hazard sequencer and the 5-stage pipeline datapath.
// The master side is the hazard controller: it observes the ID/EX/MEM
// hazard sources and drives the register enables, flushes and status.
// The slave side is the datapath that supplies those sources and obeys
// the controls.
//
// Handshake: the only request/response pair here is mem_req/mem_ready.
// mem_req is held high for as long as the instruction in MEM needs the data
// memory; the access completes in the cycle where mem_req and mem_ready are
// both high. mem_ready is don't-care while mem_req is low, and every cycle
// with mem_req high and mem_ready low is a wait cycle.
interface pipeline_hazard_ctrl_if;
    // Hazard sources from the pipeline
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [3:0]  ex_op_type;
    logic [4:0]  ex_write_reg;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;

    // Register controls back to the pipeline
    logic        pc_en;
    logic        if2id_en;
    logic        id2ex_en;
    logic        ex2mem_en;
    logic        if2id_flush;
    logic        id2ex_flush;
    logic        ex2mem_flush;
    logic        mem2wb_flush;

    // Status
    logic        mem_timeout;
    logic [15:0] stall_count;

    modport master (
        input  id_rs, id_rt, ex_op_type, ex_write_reg,
        input  branch_taken, mem_req, mem_ready,
        output pc_en, if2id_en, id2ex_en, ex2mem_en,
        output if2id_flush, id2ex_flush, ex2mem_flush, mem2wb_flush,
        output mem_timeout, stall_count
    );

    modport slave (
        output id_rs, id_rt, ex_op_type, ex_write_reg,
        output branch_taken, mem_req, mem_ready,
        input  pc_en, if2id_en, id2ex_en, ex2mem_en,
        input  if2id_flush, id2ex_flush, ex2mem_flush, mem2wb_flush,
        input  mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline.
// Resolves data-memory waits (freeze everything, bubble into WB), taken
// branches (squash IF/ID and ID/EX), and load-use interlocks (hold PC and
// IF/ID for one cycle, bubble into EX). A data-memory wait lasting
// MEM_TIMEOUT consecutive edges halts the pipeline until reset.
// A saturating counter records every cycle the PC was held.
// dbg_state exposes the FSM state: 0=RUN, 1=WAIT, 2=HALT.
module pipeline_hazard_ctrl #(
    parameter logic [3:0] OP_LOAD     = 4'd3,
    parameter int         MEM_TIMEOUT = 64      // legal range 2..255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_ctrl_if.master        hz,
    output logic [1:0]                    dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // wait_cnt value at which one more frozen edge means a timeout
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic mem_freeze;
    logic lu_hazard;

    logic pc_en, if2id_en, id2ex_en, ex2mem_en;
    logic if2id_flush, id2ex_flush, ex2mem_flush, mem2wb_flush;
    logic mem_timeout;

    // Hazard detection; loads to $0 never create a dependency
    always_comb begin
        mem_freeze = hz.mem_req & ~hz.mem_ready;
        lu_hazard  = (hz.ex_op_type == OP_LOAD) &&
                     (hz.ex_write_reg != 5'd0) &&
                     ((hz.ex_write_reg == hz.id_rs) ||
                      (hz.ex_write_reg == hz.id_rt));
    end

    // Next-state logic: track consecutive frozen edges, halt on timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_freeze) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (!mem_freeze) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // mem_ready arriving after this edge is too late
                    state_d = ST_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_HALT: begin
                state_d    = ST_HALT;
                wait_cnt_d = wait_cnt_q;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Output decode: reset forces all controls low, HALT freezes and flushes
    always_comb begin
        pc_en        = 1'b0;
        if2id_en     = 1'b0;
        id2ex_en     = 1'b0;
        ex2mem_en    = 1'b0;
        if2id_flush  = 1'b0;
        id2ex_flush  = 1'b0;
        ex2mem_flush = 1'b0;
        mem2wb_flush = 1'b0;
        mem_timeout  = 1'b0;
        if (!rst_n) begin
            // everything stays low while reset is held
        end else if (state_q == ST_HALT) begin
            if2id_flush  = 1'b1;
            id2ex_flush  = 1'b1;
            ex2mem_flush = 1'b1;
            mem2wb_flush = 1'b1;
            mem_timeout  = 1'b1;
        end else if (mem_freeze) begin
            // MEM is stuck: nothing advances, WB receives a bubble.
            // A pending branch or load-use waits until the freeze ends.
            mem2wb_flush = 1'b1;
        end else if (hz.branch_taken) begin
            // ID instruction is wrong-path, so its load-use is irrelevant
            pc_en       = 1'b1;
            if2id_en    = 1'b1;
            id2ex_en    = 1'b1;
            ex2mem_en   = 1'b1;
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (lu_hazard) begin
            // Hold fetch/decode one cycle, load moves on to MEM
            id2ex_en    = 1'b1;
            ex2mem_en   = 1'b1;
            id2ex_flush = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if2id_en  = 1'b1;
            id2ex_en  = 1'b1;
            ex2mem_en = 1'b1;
        end
    end

    // Stall counter: counts held-PC cycles outside HALT, saturating
    always_comb begin
        stall_count_d = stall_count_q;
        if ((state_q != ST_HALT) && !pc_en && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State, wait counter and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if2id_en     = if2id_en;
    assign hz.id2ex_en     = id2ex_en;
    assign hz.ex2mem_en    = ex2mem_en;
    assign hz.if2id_flush  = if2id_flush;
    assign hz.id2ex_flush  = id2ex_flush;
    assign hz.ex2mem_flush = ex2mem_flush;
    assign hz.mem2wb_flush = mem2wb_flush;
    assign hz.mem_timeout  = mem_timeout;
    assign hz.stall_count  = stall_count_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS32 pipeline. It drives the enable and flush inputs of the PC, IF2ID, ID2EX, EX2MEM and MEM2WB pipeline registers. It resolves load-use interlocks, taken-branch squashes and multi-cycle data-memory waits, and halts the pipeline on a memory timeout. It also keeps a saturating stall-cycle counter for performance inspection.

## Interface
- OP_LOAD, 4'd3: op_type code of load instructions in EX.
- MEM_TIMEOUT, 64: maximum consecutive wait cycles before halt (range 2..255).
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_op_type  in  4  op_type of the instruction in EX.
- ex_write_reg  in  5  destination register of the instruction in EX.
- branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- mem_req  in  1  instruction in MEM performs a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if2id_en, id2ex_en, ex2mem_en  out  1 each  load enables for the PC and pipeline registers.
- if2id_flush, id2ex_flush, ex2mem_flush, mem2wb_flush  out  1 each  synchronous clear (bubble insert) for the pipeline registers.
- mem_timeout  out  1  sticky error; pipeline halted.
- stall_count  out  16  saturating count of cycles with pc_en=0.

## Operation
- States: RUN, WAIT, HALT. Reset state is RUN with wait_cnt=0.
- mem_freeze = mem_req & ~mem_ready. lu_hazard = (ex_op_type==OP_LOAD) & (ex_write_reg!=0) & (ex_write_reg==id_rs | ex_write_reg==id_rt).
- Priority in RUN/WAIT, highest first; outputs are combinational from inputs and state.
  1. mem_freeze: all four enables 0; mem2wb_flush=1; all other flushes 0, even if a branch or load-use condition is present.
  2. branch_taken: all enables 1; if2id_flush=1 and id2ex_flush=1; ex2mem_flush=0. Load-use is ignored because the ID instruction is wrong-path.
  3. lu_hazard: pc_en=0, if2id_en=0; id2ex_en=1, ex2mem_en=1; id2ex_flush=1. Exactly one bubble is inserted.
  4. Otherwise: all enables 1 and all flushes 0.
- Transitions:
  - RUN -> WAIT when mem_freeze; wait_cnt<=1.
  - WAIT stays while mem_freeze, with wait_cnt+1.
  - WAIT -> RUN when ~mem_freeze; wait_cnt<=0.
  - WAIT -> HALT when mem_freeze and wait_cnt==MEM_TIMEOUT-1.
- HALT is terminal until reset. All enables 0, all flushes 1, mem_timeout=1. Inputs are ignored.
- stall_count is 16-bit. It increments by 1 on each posedge where pc_en==0 and state!=HALT, and saturates at 16'hFFFF without wrapping.
- The wait_cnt width is 8 bits.

## Timing
- While rst_n=0:
  - state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
  - All enables and flushes are forced to 0.
  - Reset mid-WAIT or in HALT returns to RUN immediately, asynchronously.
- Load-use costs exactly 1 stall cycle. The following cycle the load is in MEM, lu_hazard is false, and the pipeline advances.
- Branch squash takes effect at the same posedge the branch leaves EX, with zero added cycles of stall.
- Memory wait of N cycles (mem_ready low N cycles, then high) gives N frozen cycles and N mem2wb bubbles. The cycle mem_ready rises, enables return to 1.
- A branch_taken held in a frozen EX is not acted on until the freeze ends. It then squashes in the first unfrozen cycle.
- Timeout: mem_timeout rises at the MEM_TIMEOUT-th consecutive posedge with mem_freeze true. A mem_ready arriving in that same cycle is too late.

## Test plan
- Load-use: ex_op_type=OP_LOAD, ex_write_reg=5, id_rs=5 for one cycle -> pc_en=0, if2id_en=0, id2ex_flush=1 that cycle; all normal next cycle; stall_count=1.
- Load-use to $0: ex_write_reg=0, id_rs=0 -> no stall, stall_count stays 0.
- Branch plus load-use: branch_taken=1 with lu_hazard=1 -> pc_en=1, if2id_flush=1, id2ex_flush=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles of enables=0 and mem2wb_flush=1, id2ex_flush held 0 despite a concurrent lu_hazard; state returns to RUN; stall_count=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th edge; all flushes 1, enables 0; rst_n pulse low clears to RUN and stall_count=0.
- Saturation: force 70000 stall cycles -> stall_count=16'hFFFF and remains there.
